// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, forwarding select codes and shadow-slot type
//   REG_W        register index width
//   FWD_*        EX operand mux select encodings (11 is never produced)
//   slot_t       one shadow pipeline slot: destination register and write enable
//   fwd_sel      EX-over-MEM priority select for one operand
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef struct packed {
    logic             regwrite;
    logic [REG_W-1:0] dst;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // The younger producer (EX) holds the newest value, so it wins.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return FWD_EXMEM;
    end else if (mem_hit) begin
      return FWD_MEMWB;
    end
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - one source-register versus one shadow-slot dependency check
//   use_src  in   ID instruction actually reads this source
//   src      in   source register index
//   slot     in   shadow slot being compared against
//   hit      out  slot will write the register this source reads
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic             use_src,
  input  logic [REG_W-1:0] src,
  input  slot_t            slot,
  output logic             hit
);

  // $0 is hard-wired to zero, so a write to it never creates a dependency.
  assign hit = use_src && (src != '0) && slot.regwrite && (slot.dst == src);

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - load-use stall detection and EX operand forwarding selects
//   clk, rst_n         clock, asynchronous active-low reset
//   id_valid           ID holds a real instruction
//   id_rs/id_rt        ID source registers, qualified by id_use_rs/id_use_rt
//   id_dst             ID destination register
//   id_regwrite        ID instruction writes the register file
//   id_memread         ID instruction is a load
//   flush              squash the ID instruction
//   stall              hold PC and IF/ID (combinational)
//   ex_forward_a/b     registered EX operand mux selects
// Build option: FORWARDING_EN. Without it the selects are tied to the register
// file and any in-flight producer of a used source stalls ID.
module hazard_forward_unit
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       ex_forward_a,
  output logic [1:0]       ex_forward_b
);

  slot_t ex_slot_q, ex_slot_d;
  slot_t mem_slot_q, mem_slot_d;
  logic  ex_memread_q, ex_memread_d;

  logic rs_ex_hit, rs_mem_hit, rt_ex_hit, rt_mem_hit;
  logic ex_hit, mem_hit;
  logic id_live, advance;

  hazard_cmp u_cmp_rs_ex  (.use_src(id_use_rs), .src(id_rs), .slot(ex_slot_q),  .hit(rs_ex_hit));
  hazard_cmp u_cmp_rs_mem (.use_src(id_use_rs), .src(id_rs), .slot(mem_slot_q), .hit(rs_mem_hit));
  hazard_cmp u_cmp_rt_ex  (.use_src(id_use_rt), .src(id_rt), .slot(ex_slot_q),  .hit(rt_ex_hit));
  hazard_cmp u_cmp_rt_mem (.use_src(id_use_rt), .src(id_rt), .slot(mem_slot_q), .hit(rt_mem_hit));

  assign ex_hit  = rs_ex_hit | rt_ex_hit;
  assign mem_hit = rs_mem_hit | rt_mem_hit;

  // A flushed ID slot is dead: it never stalls, and flush therefore beats stall.
  assign id_live = id_valid & ~flush;

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time; one bubble moves it to MEM.
  assign stall = id_live & ex_hit & ex_memread_q;
`else
  // No bypass paths: wait until every in-flight producer has written back.
  assign stall = id_live & ((ex_hit & ex_memread_q) | (ex_hit & ~ex_memread_q) | mem_hit);
`endif

  assign advance = id_live & ~stall;

  always_comb begin
    ex_slot_d    = SLOT_BUBBLE;
    ex_memread_d = 1'b0;
    mem_slot_d   = ex_slot_q;
    if (advance) begin
      ex_slot_d.regwrite = id_regwrite;
      ex_slot_d.dst      = id_dst;
      ex_memread_d       = id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot_q    <= SLOT_BUBBLE;
      ex_memread_q <= 1'b0;
      mem_slot_q   <= SLOT_BUBBLE;
    end else begin
      ex_slot_q    <= ex_slot_d;
      ex_memread_q <= ex_memread_d;
      mem_slot_q   <= mem_slot_d;
    end
  end

`ifdef FORWARDING_EN
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  // Selects travel with the instruction into EX; a bubble carries register-file.
  always_comb begin
    fwd_a_d = FWD_REGFILE;
    fwd_b_d = FWD_REGFILE;
    if (advance) begin
      fwd_a_d = fwd_sel(rs_ex_hit, rs_mem_hit);
      fwd_b_d = fwd_sel(rt_ex_hit, rt_mem_hit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_REGFILE;
      fwd_b_q <= FWD_REGFILE;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign ex_forward_a = fwd_a_q;
  assign ex_forward_b = fwd_b_q;
`else
  assign ex_forward_a = FWD_REGFILE;
  assign ex_forward_b = FWD_REGFILE;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - randomized and directed checks of hazard_forward_unit
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
  logic       stall;
  logic [1:0] ex_forward_a, ex_forward_b;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall), .ex_forward_a(ex_forward_a), .ex_forward_b(ex_forward_b)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the last two instructions issued past ID, youngest first.
  typedef struct {
    bit       w;
    bit [4:0] dst;
    bit       ld;
  } ins_t;

  ins_t     hist [2];
  bit [1:0] e_fa = 2'b00;
  bit [1:0] e_fb = 2'b00;

  function automatic bit dep(input bit u, input bit [4:0] src, input ins_t e);
    return u && src != 0 && e.w && e.dst == src;
  endfunction

  function automatic bit [1:0] sel(input bit u, input bit [4:0] src);
    if (dep(u, src, hist[0])) return 2'b10;
    if (dep(u, src, hist[1])) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit d0, d1;
    if (!id_valid || flush) return 1'b0;
    d0 = dep(id_use_rs, id_rs, hist[0]) || dep(id_use_rt, id_rt, hist[0]);
    d1 = dep(id_use_rs, id_rs, hist[1]) || dep(id_use_rt, id_rt, hist[1]);
`ifdef FORWARDING_EN
    return d0 && hist[0].ld;
`else
    return d0 || d1;
`endif
  endfunction

  initial begin
    hist[0] = '{0, 0, 0};
    hist[1] = '{0, 0, 0};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist[0] = '{0, 0, 0};
      hist[1] = '{0, 0, 0};
      e_fa = 2'b00;
      e_fb = 2'b00;
    end else begin
      ins_t nw;
      bit   adv;
      adv = id_valid && !flush && !m_stall();
      nw  = adv ? '{id_regwrite, id_dst, id_memread} : '{0, 0, 0};
`ifdef FORWARDING_EN
      e_fa = adv ? sel(id_use_rs, id_rs) : 2'b00;
      e_fb = adv ? sel(id_use_rt, id_rt) : 2'b00;
`else
      e_fa = 2'b00;
      e_fb = 2'b00;
`endif
      hist[1] = hist[0];
      hist[0] = nw;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_stall", {1'b0, stall}, {1'b0, m_stall()});
      chk("cyc_fwd_a", ex_forward_a, e_fa);
      chk("cyc_fwd_b", ex_forward_b, e_fb);
    end
  end

  task automatic issue(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                       input bit ur, input bit ut, input bit [4:0] dst,
                       input bit rw, input bit mr, input bit fl);
    @(posedge clk);
    #2;
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = ur; id_use_rt = ut;
    id_dst = dst; id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with a live-looking ID instruction driven.
    id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd3; id_use_rt = 1'b1; id_rt = 5'd3;
    #12;
    chk("rst_stall", {1'b0, stall}, 2'b00);
    chk("rst_fwd_a", ex_forward_a, 2'b00);
    chk("rst_fwd_b", ex_forward_b, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(3);

`ifdef FORWARDING_EN
    // add $3 ; add rs=$3 -> EX/MEM forward, no stall
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
    issue(1, 3, 4, 1, 1, 6, 1, 0, 0);
    #1 chk("exfwd_stall", {1'b0, stall}, 2'b00);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("exfwd_a", ex_forward_a, 2'b10);
    idle(3);
    // add $3 ; nop ; sub rt=$3 -> MEM/WB forward
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 4, 3, 1, 1, 6, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("memfwd_b", ex_forward_b, 2'b01);
    idle(3);
    // lw $5 ; add rs=$5 -> one stall then MEM/WB forward
    issue(1, 1, 0, 1, 0, 5, 1, 1, 0);
    issue(1, 5, 2, 1, 1, 6, 1, 0, 0);
    #1 chk("lu_stall1", {1'b0, stall}, 2'b01);
    @(posedge clk);
    #3 chk("lu_stall2", {1'b0, stall}, 2'b00);
    chk("lu_bubble_a", ex_forward_a, 2'b00);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lu_fwd_a", ex_forward_a, 2'b01);
    idle(3);
    // $0 writer then $0 reader -> no forwarding
    issue(1, 1, 2, 1, 1, 0, 1, 0, 0);
    issue(1, 0, 0, 1, 1, 6, 1, 0, 0);
    #1 chk("zero_stall", {1'b0, stall}, 2'b00);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("zero_fwd_a", ex_forward_a, 2'b00);
    // lw $5 ; flushed dependent -> no stall
    issue(1, 1, 0, 1, 0, 5, 1, 1, 0);
    issue(1, 5, 0, 1, 0, 6, 1, 0, 1);
    #1 chk("flush_stall", {1'b0, stall}, 2'b00);
    idle(3);
    // $7 in both EX and MEM -> EX wins on both operands
    issue(1, 1, 2, 1, 1, 7, 1, 0, 0);
    issue(1, 1, 2, 1, 1, 7, 1, 0, 0);
    issue(1, 7, 7, 1, 1, 6, 1, 0, 0);
    #1 chk("prio_stall", {1'b0, stall}, 2'b00);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("prio_a", ex_forward_a, 2'b10);
    chk("prio_b", ex_forward_b, 2'b10);
    idle(3);
    // reset in the middle of a load-use stall
    issue(1, 1, 0, 1, 0, 5, 1, 1, 0);
    issue(1, 5, 0, 1, 0, 6, 1, 0, 0);
    #1 chk("rstmid_pre", {1'b0, stall}, 2'b01);
`else
    // add $3 ; reader of $3 -> two stall cycles, selects stay 00
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
    issue(1, 3, 4, 1, 1, 6, 1, 0, 0);
    #1 chk("nf_stall1", {1'b0, stall}, 2'b01);
    @(posedge clk);
    #3 chk("nf_stall2", {1'b0, stall}, 2'b01);
    @(posedge clk);
    #3 chk("nf_stall3", {1'b0, stall}, 2'b00);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("nf_fwd_a", ex_forward_a, 2'b00);
    // flushed dependent never stalls
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
    issue(1, 3, 0, 1, 0, 6, 1, 0, 1);
    #1 chk("nf_flush", {1'b0, stall}, 2'b00);
    idle(3);
    // reset in the middle of a stall
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
    issue(1, 0, 3, 0, 1, 6, 1, 0, 0);
    #1 chk("rstmid_pre", {1'b0, stall}, 2'b01);
`endif
    rst_n = 1'b0;
    #1 chk("rstmid_stall", {1'b0, stall}, 2'b00);
    chk("rstmid_fwd_a", ex_forward_a, 2'b00);
    chk("rstmid_fwd_b", ex_forward_b, 2'b00);
    rst_n = 1'b1;
    #1 chk("rstmid_after", {1'b0, stall}, 2'b00);
    idle(3);

    // Randomized traffic on a small register set so dependencies are frequent.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      id_valid    = ($urandom_range(0, 9) < 8);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_use_rs   = $urandom_range(0, 3) != 0;
      id_use_rt   = $urandom_range(0, 1) != 0;
      id_dst      = 5'($urandom_range(0, 3));
      id_regwrite = $urandom_range(0, 3) != 0;
      id_memread  = $urandom_range(0, 2) == 0;
      flush       = $urandom_range(0, 9) == 0;
    end
    idle(2);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
